// File: rtl/signed_fixed_point_divider_if.sv
// Start/done handshake and operand/result bundle for signed_fixed_point_divider.
//   start_in        request, sampled by the divider only while idle
//   dividend_in     signed Q dividend, captured on accepted start
//   divisor_in      signed Q divisor, captured on accepted start
//   busy_out        high while a division is in progress
//   done_out        one-cycle pulse, result valid
//   quotient_out    signed Q quotient, held until the next done_out
//   overflow_out    result saturated
//   div_by_zero_out divisor was zero
// master: requester side; slave: divider side.
interface signed_fixed_point_divider_if #(
   parameter int FIXED_POINT_WIDTH = 16
);
   logic                         start_in;
   logic [FIXED_POINT_WIDTH-1:0] dividend_in;
   logic [FIXED_POINT_WIDTH-1:0] divisor_in;
   logic                         busy_out;
   logic                         done_out;
   logic [FIXED_POINT_WIDTH-1:0] quotient_out;
   logic                         overflow_out;
   logic                         div_by_zero_out;

   modport master (
      output start_in, dividend_in, divisor_in,
      input  busy_out, done_out, quotient_out, overflow_out, div_by_zero_out
   );

   modport slave (
      input  start_in, dividend_in, divisor_in,
      output busy_out, done_out, quotient_out, overflow_out, div_by_zero_out
   );
endinterface

// File: rtl/signed_fixed_point_divider.sv
// Iterative signed fixed-point divider (restoring, radix 2, one quotient bit
// per clock). quotient = dividend / divisor in the operands' Qm.n format,
// truncated toward zero and saturated on overflow.
// Ports:
//   clk_in    single clock, rising edge
//   rst_n_in  asynchronous active-low reset
//   bus       slave side of signed_fixed_point_divider_if (start/operands in,
//             busy/done/quotient/overflow/div_by_zero out)
// Latency: done_out is high in the cycle after edge N+1 following the start edge,
// N = FIXED_POINT_WIDTH + FIXED_POINT_POSITION.
module signed_fixed_point_divider #(
   parameter int FIXED_POINT_WIDTH    = 16,
   parameter int FIXED_POINT_POSITION = 10
) (
   input logic                            clk_in,
   input logic                            rst_n_in,
   signed_fixed_point_divider_if.slave    bus
);

   localparam int W     = FIXED_POINT_WIDTH;
   localparam int F     = FIXED_POINT_POSITION;
   localparam int N     = W + F;
   localparam int CNT_W = $clog2(N);

   localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      DIVIDE,
      FINISH
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Numerator shifts out MSB-first; quotient bits shift in at the LSB, so at
   // the end this register holds the N-bit unsigned quotient magnitude.
   logic [N-1:0]     num_q, num_d;
   // Remainder always stays below the divisor magnitude (<= 2^(W-1)), so W bits suffice.
   logic [W-1:0]     rem_q, rem_d;
   logic [W-1:0]     div_q, div_d;
   logic             neg_q, neg_d;
   logic             dvd_neg_q, dvd_neg_d;
   logic             dvz_q, dvz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [W-1:0]     quo_q, quo_d;
   logic             ovf_q, ovf_d;
   logic             dbz_q, dbz_d;

   logic [W:0]       rem_shift;
   logic [W-1:0]     dvd_abs;
   logic [W-1:0]     dvs_abs;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         num_q     <= '0;
         rem_q     <= '0;
         div_q     <= '0;
         neg_q     <= 1'b0;
         dvd_neg_q <= 1'b0;
         dvz_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         quo_q     <= '0;
         ovf_q     <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         num_q     <= num_d;
         rem_q     <= rem_d;
         div_q     <= div_d;
         neg_q     <= neg_d;
         dvd_neg_q <= dvd_neg_d;
         dvz_q     <= dvz_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         quo_q     <= quo_d;
         ovf_q     <= ovf_d;
         dbz_q     <= dbz_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      num_d     = num_q;
      rem_d     = rem_q;
      div_d     = div_q;
      neg_d     = neg_q;
      dvd_neg_d = dvd_neg_q;
      dvz_d     = dvz_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      quo_d     = quo_q;
      ovf_d     = ovf_q;
      dbz_d     = dbz_q;

      // |min| = 2^(W-1) is representable as a W-bit unsigned value.
      dvd_abs   = bus.dividend_in[W-1] ? ('0 - bus.dividend_in) : bus.dividend_in;
      dvs_abs   = bus.divisor_in[W-1]  ? ('0 - bus.divisor_in)  : bus.divisor_in;
      rem_shift = {rem_q, num_q[N-1]};

      case (state_q)
         IDLE: begin
            if (bus.start_in) begin
               state_d   = DIVIDE;
               busy_d    = 1'b1;
               cnt_d     = CNT_W'(N - 1);
               num_d     = {dvd_abs, {F{1'b0}}};
               rem_d     = '0;
               div_d     = dvs_abs;
               // Zero dividend forces a positive result.
               neg_d     = (bus.dividend_in[W-1] ^ bus.divisor_in[W-1]) &&
                           (bus.dividend_in != '0);
               dvd_neg_d = bus.dividend_in[W-1];
               dvz_d     = (bus.divisor_in == '0);
               ovf_d     = 1'b0;
               dbz_d     = 1'b0;
            end
         end

         DIVIDE: begin
            if (rem_shift >= {1'b0, div_q}) begin
               rem_d = W'(rem_shift - {1'b0, div_q});
               num_d = {num_q[N-2:0], 1'b1};
            end else begin
               rem_d = rem_shift[W-1:0];
               num_d = {num_q[N-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               state_d = FINISH;
            end
         end

         FINISH: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (dvz_q) begin
               quo_d = dvd_neg_q ? MIN_NEG : MAX_POS;
               dbz_d = 1'b1;
               ovf_d = 1'b0;
            end else if (!neg_q) begin
               // Positive overflow: magnitude >= 2^(W-1).
               if (|num_q[N-1:W-1]) begin
                  quo_d = MAX_POS;
                  ovf_d = 1'b1;
               end else begin
                  quo_d = num_q[W-1:0];
               end
            end else begin
               // Negative overflow: magnitude > 2^(W-1); exactly 2^(W-1) maps to min.
               if ((|num_q[N-1:W]) || (num_q[W-1] && (|num_q[W-2:0]))) begin
                  quo_d = MIN_NEG;
                  ovf_d = 1'b1;
               end else begin
                  quo_d = '0 - num_q[W-1:0];
               end
            end
         end

         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign bus.busy_out        = busy_q;
   assign bus.done_out        = done_q;
   assign bus.quotient_out    = quo_q;
   assign bus.overflow_out    = ovf_q;
   assign bus.div_by_zero_out = dbz_q;

endmodule

// File: tb/tb_signed_fixed_point_divider.sv
// Scoreboard bench for signed_fixed_point_divider at W=16, F=10.
module tb_signed_fixed_point_divider;

   localparam int W   = 16;
   localparam int F   = 10;
   localparam int LAT = W + F + 1;

   typedef struct {
      logic [W-1:0] q;
      logic         ovf;
      logic         dbz;
      int           acc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_err;
   int   n_done;
   int   n_push;
   logic [W-1:0] last_q;
   exp_t sb[$];

   signed_fixed_point_divider_if #(.FIXED_POINT_WIDTH(W)) bus ();

   signed_fixed_point_divider #(
      .FIXED_POINT_WIDTH   (W),
      .FIXED_POINT_POSITION(F)
   ) dut (
      .clk_in  (clk),
      .rst_n_in(rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Independent reference using wide integer arithmetic.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t   e;
      longint la, lb, mag, v;
      la = longint'($signed(a));
      lb = longint'($signed(b));
      e.acc = 0;
      e.ovf = 1'b0;
      e.dbz = 1'b0;
      if (lb == 0) begin
         e.q   = (la < 0) ? 16'h8000 : 16'h7FFF;
         e.dbz = 1'b1;
      end else begin
         mag = ((la < 0 ? -la : la) * 1024) / (lb < 0 ? -lb : lb);
         v   = ((la < 0) != (lb < 0)) ? -mag : mag;
         if (v > 32767) begin
            e.q = 16'h7FFF; e.ovf = 1'b1;
         end else if (v < -32768) begin
            e.q = 16'h8000; e.ovf = 1'b1;
         end else begin
            e.q = 16'(v);
         end
      end
      return e;
   endfunction

   // Scoreboard monitor, sampled away from the clock edge.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (bus.done_out === 1'b1) begin
         n_done++;
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("quotient", 32'(bus.quotient_out), 32'(e.q));
            chk("overflow", 32'(bus.overflow_out), 32'(e.ovf));
            chk("div_by_zero", 32'(bus.div_by_zero_out), 32'(e.dbz));
            chk("latency", 32'(cyc - e.acc), 32'(LAT));
            chk("busy_at_done", 32'(bus.busy_out), 32'd0);
         end
      end
   end

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < LAT + 10; i++) begin
         @(posedge clk);
         #1;
         if (bus.done_out === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   // Issue one division; called right after the previous done so the start
   // lands in the done cycle (back-to-back).
   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e_in, input bit poke);
      exp_t e;
      e = e_in;
      @(negedge clk);
      bus.start_in    = 1'b1;
      bus.dividend_in = a;
      bus.divisor_in  = b;
      @(posedge clk);
      #1;
      bus.start_in    = 1'b0;
      bus.dividend_in = W'($urandom);
      bus.divisor_in  = W'($urandom);
      e.acc = cyc;
      sb.push_back(e);
      n_push++;
      chk("busy_on_start", 32'(bus.busy_out), 32'd1);
      chk("ovf_cleared", 32'(bus.overflow_out), 32'd0);
      chk("dbz_cleared", 32'(bus.div_by_zero_out), 32'd0);
      chk("quotient_held", 32'(bus.quotient_out), 32'(last_q));
      if (poke) begin
         repeat (5) @(negedge clk);
         bus.start_in    = 1'b1;
         bus.dividend_in = 16'h7000;
         bus.divisor_in  = 16'h0001;
         @(negedge clk);
         bus.start_in    = 1'b0;
      end
      wait_done();
      last_q = e.q;
   endtask

   function automatic exp_t mk(input logic [W-1:0] q, input logic ovf, input logic dbz);
      exp_t e;
      e.q = q; e.ovf = ovf; e.dbz = dbz; e.acc = 0;
      return e;
   endfunction

   logic [W-1:0] va[12];
   logic [W-1:0] vb[12];
   exp_t         ve[12];

   initial begin
      logic [W-1:0] ra, rb;
      cyc = 0; n_checks = 0; n_err = 0; n_done = 0; n_push = 0; last_q = '0;
      bus.start_in = 1'b0; bus.dividend_in = '0; bus.divisor_in = '0;
      rst_n = 1'b0;

      va[0]  = 16'h0C00; vb[0]  = 16'h0800; ve[0]  = mk(16'h0600, 0, 0);
      va[1]  = 16'hFA00; vb[1]  = 16'h0200; ve[1]  = mk(16'hF400, 0, 0);
      va[2]  = 16'h0400; vb[2]  = 16'h0C00; ve[2]  = mk(16'h0155, 0, 0);
      va[3]  = 16'hFC00; vb[3]  = 16'h0C00; ve[3]  = mk(16'hFEAB, 0, 0);
      va[4]  = 16'h4000; vb[4]  = 16'h0100; ve[4]  = mk(16'h7FFF, 1, 0);
      va[5]  = 16'h8000; vb[5]  = 16'h0400; ve[5]  = mk(16'h8000, 0, 0);
      va[6]  = 16'hF000; vb[6]  = 16'h0000; ve[6]  = mk(16'h8000, 0, 1);
      va[7]  = 16'h0000; vb[7]  = 16'h0000; ve[7]  = mk(16'h7FFF, 0, 1);
      va[8]  = 16'h0000; vb[8]  = 16'hFC00; ve[8]  = mk(16'h0000, 0, 0);
      va[9]  = 16'hC000; vb[9]  = 16'h0100; ve[9]  = mk(16'h8000, 1, 0);
      va[10] = 16'h8000; vb[10] = 16'hFC00; ve[10] = mk(16'h7FFF, 1, 0);
      va[11] = 16'h8000; vb[11] = 16'h8000; ve[11] = mk(16'h0400, 0, 0);

      #12;
      chk("rst_quotient", 32'(bus.quotient_out), 32'd0);
      chk("rst_busy", 32'(bus.busy_out), 32'd0);
      chk("rst_done", 32'(bus.done_out), 32'd0);
      chk("rst_ovf", 32'(bus.overflow_out), 32'd0);
      chk("rst_dbz", 32'(bus.div_by_zero_out), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 12; i++) do_div(va[i], vb[i], ve[i], 1'b0);

      // Start pulsed mid-divide with different operands must be ignored.
      do_div(16'h0400, 16'h0C00, mk(16'h0155, 0, 0), 1'b1);

      for (int i = 0; i < 12; i++) begin
         ra = W'($urandom);
         rb = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom);
         if (rb == '0) rb = 16'h0001;
         do_div(ra, rb, model(ra, rb), 1'b0);
      end

      // Reset in the middle of an operation aborts it.
      @(negedge clk);
      bus.start_in = 1'b1; bus.dividend_in = 16'h0C00; bus.divisor_in = 16'h0800;
      @(negedge clk);
      bus.start_in = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort_quotient", 32'(bus.quotient_out), 32'd0);
      chk("abort_busy", 32'(bus.busy_out), 32'd0);
      chk("abort_ovf", 32'(bus.overflow_out), 32'd0);
      chk("abort_dbz", 32'(bus.div_by_zero_out), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      last_q = '0;
      repeat (LAT + 3) begin
         @(posedge clk);
         #1;
         chk("abort_no_done", 32'(bus.done_out), 32'd0);
      end

      do_div(16'h0C00, 16'h0800, mk(16'h0600, 0, 0), 1'b0);
      do_div(16'hFA00, 16'h0200, model(16'hFA00, 16'h0200), 1'b0);

      repeat (3) @(posedge clk);
      #3;
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      chk("done_count", 32'(n_done), 32'(n_push));
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
